// File: rtl/ft_ch_sched.sv
// Channel scheduler for the FT600 FIFO-master FSM: one round-robin over NCH write
// and NCH read slots, one-cycle grant, completion tracking and a post-transfer gap.
module ft_ch_sched #(
    parameter int NCH     = 4,
    parameter int EPm_MSZ = 11,
    parameter int GAP_CYC = 2,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           en,
    input  logic [NCH-1:0]                 wr_req,
    input  logic [NCH-1:0]                 rd_req,
    input  logic                           idle_st,
    input  logic [NCH*(EPm_MSZ+1)-1:0]     ep_rd_ptr_bus,
    output logic                           grant,
    output logic                           m_rd_wr,
    output logic [CH_W-1:0]                ch_sel,
    output logic [EPm_MSZ:0]               ep_rd_ptr,
    output logic                           busy,
    output logic                           txn_done,
    output logic                           grant_err
);

    // state   | meaning
    // S_IDLE  | waiting for enable, master idle and any request
    // S_ARB   | pick winner from rr_ptr, latch direction/channel
    // S_GRANT | one-cycle grant to the master FSM
    // S_WAIT0 | waiting for the master to leave idle (3-cycle watchdog)
    // S_BUSY  | transfer in progress until the master returns to idle
    // S_GAP   | GAP_CYC cycles of enforced inter-transaction spacing
    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_GRANT, S_WAIT0, S_BUSY, S_GAP
    } state_t;

    localparam int             NS     = 2 * NCH;
    localparam int             PTR_W  = $clog2(NS);
    localparam logic [1:0]     WD_LD  = 2'd2;
    localparam logic [3:0]     GAP_LD = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_nxt;
    logic [PTR_W-1:0]   win_q;
    logic [PTR_W-1:0]   win_slot;
    logic [PTR_W-1:0]   idx_p;
    logic               win_found;
    logic               win_rw;
    logic [CH_W-1:0]    win_ch;
    logic [NS-1:0]      req_vec;
    logic [1:0]         wd_cnt;
    logic [3:0]         gap_cnt;

    // Write slots occupy the low half so slot index == channel for writes.
    assign req_vec = {rd_req, wr_req};

    always_comb begin
        win_found = 1'b0;
        win_slot  = '0;
        idx_p     = '0;
        for (int k = 0; k < NS; k++) begin
            idx_p = PTR_W'((int'(rr_ptr) + k) % NS);
            if (!win_found && req_vec[idx_p]) begin
                win_found = 1'b1;
                win_slot  = idx_p;
            end
        end
    end

    assign win_rw = (int'(win_slot) >= NCH);
    assign win_ch = win_rw ? CH_W'(int'(win_slot) - NCH) : CH_W'(win_slot);
    assign rr_nxt = (int'(win_q) == NS - 1) ? '0 : win_q + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en && idle_st && (|req_vec)) state_nxt = S_ARB;
            S_ARB:   state_nxt = win_found ? S_GRANT : S_IDLE;
            S_GRANT: state_nxt = S_WAIT0;
            S_WAIT0: begin
                if (!idle_st)
                    state_nxt = S_BUSY;
                else if (wd_cnt == '0)
                    state_nxt = S_IDLE;
            end
            S_BUSY:  if (idle_st) state_nxt = (GAP_CYC == 0) ? S_IDLE : S_GAP;
            S_GAP:   if (gap_cnt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pulses are gated by rstn so a reset landing on the completing cycle abandons it cleanly.
    assign grant     = (state == S_GRANT);
    assign busy      = (state != S_IDLE);
    assign txn_done  = rstn && (state == S_BUSY) && idle_st;
    assign grant_err = rstn && (state == S_WAIT0) && idle_st && (wd_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            rr_ptr  <= '0;
            win_q   <= '0;
            m_rd_wr <= 1'b0;
            ch_sel  <= '0;
            wd_cnt  <= '0;
            gap_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_ARB && win_found) begin
                win_q   <= win_slot;
                m_rd_wr <= win_rw;
                ch_sel  <= win_ch;
            end
            if (state == S_GRANT)
                wd_cnt <= WD_LD;
            else if (state == S_WAIT0 && idle_st && wd_cnt != '0)
                wd_cnt <= wd_cnt - 1'b1;
            // rr_ptr only advances on completion, so a lost grant re-serves the same slot.
            if (txn_done) begin
                rr_ptr  <= rr_nxt;
                gap_cnt <= GAP_LD;
            end else if (state == S_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    assign ep_rd_ptr = ep_rd_ptr_bus[int'(ch_sel)*(EPm_MSZ+1) +: (EPm_MSZ+1)];

endmodule
